// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, default reset PC and fault-state type for the fetch stage.
package fetch_pkg;
  localparam int PC_W = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = '0;
  typedef enum logic {FETCH_RUN, FETCH_FAULT} fetch_state_t;
endpackage

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt: wrapping counters of issued fetches and decode-stalled valid cycles.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        stall_hit,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall_cycles
);
  logic [31:0] fetched_q, fetched_d, stalls_q, stalls_d;
  always_comb begin
    fetched_d = fetch_en ? fetched_q + 32'd1 : fetched_q;
    stalls_d = stall_hit ? stalls_q + 32'd1 : stalls_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      stalls_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      stalls_q <= stalls_d;
    end
  end
  assign perf_fetched = fetched_q;
  assign perf_stall_cycles = stalls_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and IF/ID tagger for a one-cycle-latency instruction memory.
// Define FETCH_PERF_CNT_EN to add the perf_fetched / perf_stall_cycles counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_BYTES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] addr,
  output logic        EnIM,
  output logic [31:0] id_pc,
  output logic        id_valid,
  output logic        fetch_fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall_cycles
`endif
);
  localparam int AW = PC_W + 1;
  logic [PC_W-1:0] pc_q, pc_d, id_pc_q, id_pc_d;
  logic id_valid_q, id_valid_d;
  fetch_state_t state_q, state_d;
  logic [AW-1:0] pc_end;
  logic in_range;
  // widened so a PC near 2^32 cannot wrap into range
  assign pc_end = {1'b0, pc_q} + AW'(INSTR_BYTES);
  assign in_range = pc_end <= AW'(IMEM_BYTES);
  always_comb begin
    EnIM = !rst && !redirect && !stall && state_q == FETCH_RUN && in_range;
    pc_d = pc_q;
    id_pc_d = id_pc_q;
    id_valid_d = id_valid_q;
    state_d = state_q;
    if (redirect) begin
      pc_d = {redirect_pc[31:2], 2'b00};
      id_valid_d = 1'b0;
      state_d = FETCH_RUN;
    end else if (state_q == FETCH_FAULT) begin
      id_valid_d = 1'b0;
    end else if (!stall) begin
      pc_d = in_range ? pc_q + PC_W'(INSTR_BYTES) : pc_q;
      id_pc_d = in_range ? pc_q : id_pc_q;
      id_valid_d = in_range;
      state_d = in_range ? FETCH_RUN : FETCH_FAULT;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      id_pc_q <= '0;
      id_valid_q <= 1'b0;
      state_q <= FETCH_RUN;
    end else begin
      pc_q <= pc_d;
      id_pc_q <= id_pc_d;
      id_valid_q <= id_valid_d;
      state_q <= state_d;
    end
  end
  assign addr = pc_q;
  assign id_pc = id_pc_q;
  assign id_valid = id_valid_q;
  assign fetch_fault = state_q == FETCH_FAULT;
`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf (
    .clk               (clk),
    .rst               (rst),
    .fetch_en          (EnIM),
    .stall_hit         (stall && id_valid_q),
    .perf_fetched      (perf_fetched),
    .perf_stall_cycles (perf_stall_cycles)
  );
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven check of fetch_unit against a 32-byte big-endian memory model.
module tb_fetch_unit;
  logic clk = 0, rst = 1, stall = 0, redirect = 0;
  logic [31:0] redirect_pc = 0, addr, id_pc;
  logic EnIM, id_valid, fetch_fault;
  logic [31:0] instr;
  logic [7:0] mem [32];
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall_cycles;
`endif
  int n_chk = 0, n_fail = 0;

  fetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .addr(addr), .EnIM(EnIM), .id_pc(id_pc), .id_valid(id_valid), .fetch_fault(fetch_fault)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (EnIM) instr <= {mem[addr[4:0]], mem[addr[4:0] + 5'd1], mem[addr[4:0] + 5'd2], mem[addr[4:0] + 5'd3]};

  typedef struct {
    logic r, s, d;
    logic [31:0] rpc, a;
    logic en;
    logic [31:0] ipc;
    logic iv, f;
  } vec_t;

  typedef struct {
    logic [31:0] pc, w;
  } sb_t;

  vec_t vecs[28];
  sb_t sb[$];

  function automatic vec_t v(logic r, logic s, logic d, logic [31:0] rpc, logic [31:0] a,
                             logic en, logic [31:0] ipc, logic iv, logic f);
    vec_t t;
    t.r = r; t.s = s; t.d = d; t.rpc = rpc; t.a = a; t.en = en; t.ipc = ipc; t.iv = iv; t.f = f;
    return t;
  endfunction

  function automatic logic [31:0] word(logic [31:0] a);
    logic [7:0] b;
    b = 8'hA0 + a[7:0];
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    sb_t e;
    logic prev_en;
    for (int i = 0; i < 32; i++) mem[i] = 8'hA0 + 8'(i);
    //         r  s  d  rpc     addr    en ipc    iv f
    vecs[0]  = v(0, 0, 0, 32'h00, 32'h00, 1, 32'h00, 0, 0);
    vecs[1]  = v(0, 0, 0, 32'h00, 32'h04, 1, 32'h00, 1, 0);
    vecs[2]  = v(0, 0, 0, 32'h00, 32'h08, 1, 32'h04, 1, 0);
    vecs[3]  = v(0, 1, 0, 32'h00, 32'h0C, 0, 32'h08, 1, 0);
    vecs[4]  = v(0, 1, 0, 32'h00, 32'h0C, 0, 32'h08, 1, 0);
    vecs[5]  = v(0, 1, 0, 32'h00, 32'h0C, 0, 32'h08, 1, 0);
    vecs[6]  = v(0, 0, 0, 32'h00, 32'h0C, 1, 32'h08, 1, 0);
    vecs[7]  = v(0, 0, 0, 32'h00, 32'h10, 1, 32'h0C, 1, 0);
    vecs[8]  = v(0, 0, 1, 32'h06, 32'h14, 0, 32'h10, 1, 0);
    vecs[9]  = v(0, 0, 0, 32'h00, 32'h04, 1, 32'h10, 0, 0);
    vecs[10] = v(0, 1, 1, 32'h1C, 32'h08, 0, 32'h04, 1, 0);
    vecs[11] = v(0, 0, 0, 32'h00, 32'h1C, 1, 32'h04, 0, 0);
    vecs[12] = v(0, 0, 0, 32'h00, 32'h20, 0, 32'h1C, 1, 0);
    vecs[13] = v(0, 0, 0, 32'h00, 32'h20, 0, 32'h1C, 0, 1);
    vecs[14] = v(0, 1, 0, 32'h00, 32'h20, 0, 32'h1C, 0, 1);
    vecs[15] = v(0, 0, 1, 32'h00, 32'h20, 0, 32'h1C, 0, 1);
    vecs[16] = v(0, 0, 0, 32'h00, 32'h00, 1, 32'h1C, 0, 0);
    vecs[17] = v(0, 0, 0, 32'h00, 32'h04, 1, 32'h00, 1, 0);
    vecs[18] = v(0, 0, 0, 32'h00, 32'h08, 1, 32'h04, 1, 0);
    vecs[19] = v(0, 0, 0, 32'h00, 32'h0C, 1, 32'h08, 1, 0);
    vecs[20] = v(0, 0, 0, 32'h00, 32'h10, 1, 32'h0C, 1, 0);
    vecs[21] = v(0, 1, 0, 32'h00, 32'h14, 0, 32'h10, 1, 0);
    vecs[22] = v(1, 1, 0, 32'h00, 32'h14, 0, 32'h10, 1, 0);
    vecs[23] = v(0, 0, 0, 32'h00, 32'h00, 1, 32'h00, 0, 0);
    vecs[24] = v(0, 0, 1, 32'h22, 32'h04, 0, 32'h00, 1, 0);
    vecs[25] = v(0, 1, 0, 32'h00, 32'h20, 0, 32'h00, 0, 0);
    vecs[26] = v(0, 0, 0, 32'h00, 32'h20, 0, 32'h00, 0, 0);
    vecs[27] = v(0, 0, 0, 32'h00, 32'h20, 0, 32'h00, 0, 1);
    repeat (2) @(negedge clk);
    #2;
    chk("reset EnIM", 32'(EnIM), 32'd0);
    chk("reset addr", addr, 32'h0);
    prev_en = 0;
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      rst = vecs[i].r; stall = vecs[i].s; redirect = vecs[i].d; redirect_pc = vecs[i].rpc;
      #2;
      chk($sformatf("v%0d addr", i), addr, vecs[i].a);
      chk($sformatf("v%0d EnIM", i), 32'(EnIM), 32'(vecs[i].en));
      chk($sformatf("v%0d id_pc", i), id_pc, vecs[i].ipc);
      chk($sformatf("v%0d id_valid", i), 32'(id_valid), 32'(vecs[i].iv));
      chk($sformatf("v%0d fetch_fault", i), 32'(fetch_fault), 32'(vecs[i].f));
      if (prev_en) begin
        if (sb.size() == 0) chk($sformatf("v%0d sb empty", i), 32'd0, 32'd1);
        else begin
          e = sb.pop_front();
          chk($sformatf("v%0d sb id_pc", i), id_pc, e.pc);
          chk($sformatf("v%0d sb instr", i), instr, e.w);
        end
      end
      if (vecs[i].iv) chk($sformatf("v%0d instr", i), instr, word(vecs[i].ipc));
`ifdef FETCH_PERF_CNT_EN
      if (i == 23) begin
        chk("perf_fetched after rst", perf_fetched, 32'd0);
        chk("perf_stall_cycles after rst", perf_stall_cycles, 32'd0);
      end
`endif
      if (vecs[i].en) begin
        e.pc = vecs[i].a;
        e.w = word(vecs[i].a);
        sb.push_back(e);
      end
      prev_en = vecs[i].en;
    end
    @(negedge clk);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
